// File: rtl/music_pkg.sv
// Shared field widths, FSM states and the pitch-to-period table for the
// music sequencer and its score ROM.
package music_pkg;

  localparam int PERIOD_BITS = 10;
  localparam int PITCH_W     = 6;
  localparam int DUR_W       = 4;
  localparam int ENTRY_W     = PITCH_W + DUR_W;

  localparam logic [PITCH_W-1:0] PITCH_REST = 6'd0;
  localparam logic [PITCH_W-1:0] PITCH_END  = 6'd63;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_PLAY  = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  // Tone half-periods in clocks, one equal-tempered semitone apart; entry 0 is pitch 1.
  localparam logic [PERIOD_BITS-1:0] PERIOD_TABLE [62] = '{
    10'd1000, 10'd944, 10'd891, 10'd841, 10'd794, 10'd749,
    10'd707,  10'd667, 10'd630, 10'd595, 10'd561, 10'd530,
    10'd500,  10'd472, 10'd445, 10'd420, 10'd397, 10'd375,
    10'd354,  10'd334, 10'd315, 10'd297, 10'd281, 10'd265,
    10'd250,  10'd236, 10'd223, 10'd210, 10'd198, 10'd187,
    10'd177,  10'd167, 10'd157, 10'd149, 10'd140, 10'd132,
    10'd125,  10'd118, 10'd111, 10'd105, 10'd99,  10'd94,
    10'd88,   10'd83,  10'd79,  10'd74,  10'd70,  10'd66,
    10'd63,   10'd59,  10'd56,  10'd53,  10'd50,  10'd47,
    10'd44,   10'd42,  10'd39,  10'd37,  10'd35,  10'd33,
    10'd31,   10'd29
  };

  function automatic logic [PERIOD_BITS-1:0] pitch_period(input logic [PITCH_W-1:0] pitch);
    logic [PERIOD_BITS-1:0] period;
    period = '0;
    if (pitch != PITCH_REST && pitch != PITCH_END)
      period = PERIOD_TABLE[pitch - 6'd1];
    return period;
  endfunction

endpackage

// File: rtl/music_sequencer_score_rom.sv
// Combinational score ROM: step index in, {pitch, dur} entry out.
module score_rom
  import music_pkg::*;
#(
  parameter int STEP_W = 7
) (
  input  logic [STEP_W-1:0]  i_step,
  output logic [ENTRY_W-1:0] o_entry
);

  // Unlisted steps read as the end marker, so the song loops after its last note.
  always_comb begin
    o_entry = {PITCH_END, 4'd0};
    case (i_step)
      STEP_W'(0): o_entry = {6'd10, 4'd3};
      STEP_W'(1): o_entry = {PITCH_REST, 4'd1};
      STEP_W'(2): o_entry = {6'd20, 4'd0};
      STEP_W'(3): o_entry = {6'd21, 4'd0};
      STEP_W'(4): o_entry = {6'd22, 4'd2};
      default:    o_entry = {PITCH_END, 4'd0};
    endcase
  end

endmodule

// File: rtl/music_sequencer.sv
// Score player: walks the score ROM at a selectable tempo and drives the tone
// half-period, gate, step index and beat/loop pulses.
module music_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV  = 196608,
  parameter int SCORE_LEN = 128,
  parameter int PERIOD_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         restart,
  input  logic [1:0]                   tempo_sel,
  output logic [PERIOD_W-1:0]          low_count,
  output logic                         note_on,
  output logic                         note_strobe,
  output logic [$clog2(SCORE_LEN)-1:0] crotchet,
  output logic                         beat_tick,
  output logic                         loop_pulse
);

  localparam int STEP_W = $clog2(SCORE_LEN);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SCORE_LEN - 1);

  seq_state_t          r_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TICK_W-1:0]   r_tick_lim;
  logic [DUR_W-1:0]    r_dur_cnt;
  logic [PERIOD_W-1:0] r_low_count;
  logic [STEP_W-1:0]   r_crotchet;
  logic                r_note_on;
  logic                r_note_strobe;
  logic                r_beat_tick;
  logic                r_loop_pulse;

  logic [ENTRY_W-1:0]  w_entry;
  logic [PITCH_W-1:0]  w_pitch;
  logic [DUR_W-1:0]    w_dur;
  logic [TICK_W-1:0]   w_new_lim;
  logic [STEP_W-1:0]   w_next_step;
  logic                w_wrap_step;
  logic                w_is_end;
  logic                w_counting;
  logic                w_beat;

  score_rom #(.STEP_W(STEP_W)) u_rom (
    .i_step  (r_crotchet),
    .o_entry (w_entry)
  );

  assign w_pitch     = w_entry[ENTRY_W-1 -: PITCH_W];
  assign w_dur       = w_entry[DUR_W-1:0];
  assign w_is_end    = (w_pitch == PITCH_END);
  assign w_counting  = run && (r_state != ST_FETCH);
  assign w_beat      = w_counting && (r_tick_cnt == r_tick_lim) && !restart;
  // TICK_DIV is a multiple of 8, so (TICK_DIV >> s) - 1 equals (TICK_DIV - 1) >> s.
  assign w_new_lim   = TICK_MAX >> tempo_sel;
  assign w_wrap_step = (r_crotchet == LAST_STEP);
  assign w_next_step = w_wrap_step ? '0 : r_crotchet + STEP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_tick_cnt    <= '0;
      r_tick_lim    <= TICK_MAX;
      r_dur_cnt     <= '0;
      r_low_count   <= '0;
      r_crotchet    <= '0;
      r_note_on     <= 1'b0;
      r_note_strobe <= 1'b0;
      r_beat_tick   <= 1'b0;
      r_loop_pulse  <= 1'b0;
    end else begin
      r_note_strobe <= 1'b0;
      r_loop_pulse  <= 1'b0;
      r_beat_tick   <= w_beat;
      if (restart) begin
        r_state    <= ST_FETCH;
        r_crotchet <= '0;
        r_tick_cnt <= '0;
        r_tick_lim <= w_new_lim;
        r_note_on  <= 1'b0;
      end else begin
        if (w_counting) begin
          if (w_beat) begin
            r_tick_cnt <= '0;
            r_tick_lim <= w_new_lim;
          end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
          end
        end
        case (r_state)
          ST_FETCH: begin
            if (run) begin
              // Skipping an end marker right after a loop keeps an empty score pulsing instead of stuck high.
              if (w_is_end) begin
                if (!r_loop_pulse) begin
                  r_crotchet   <= '0;
                  r_loop_pulse <= 1'b1;
                end
              end else begin
                r_low_count   <= PERIOD_W'(pitch_period(w_pitch));
                r_dur_cnt     <= w_dur;
                r_note_strobe <= 1'b1;
                r_note_on     <= (w_pitch != PITCH_REST);
                r_state       <= ST_PLAY;
              end
            end
          end
          ST_PLAY: begin
            if (w_beat) begin
              if (r_dur_cnt == '0) begin
                r_crotchet   <= w_next_step;
                r_loop_pulse <= w_wrap_step;
                r_state      <= ST_FETCH;
              end else if (r_dur_cnt == DUR_W'(1)) begin
                r_note_on <= 1'b0;
                r_state   <= ST_GAP;
              end else begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (w_beat) begin
              r_crotchet   <= w_next_step;
              r_loop_pulse <= w_wrap_step;
              r_state      <= ST_FETCH;
            end
          end
          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

  assign low_count   = r_low_count;
  assign note_on     = r_note_on & run;
  assign note_strobe = r_note_strobe;
  assign crotchet    = r_crotchet;
  assign beat_tick   = r_beat_tick;
  assign loop_pulse  = r_loop_pulse;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with an 8-clock tick: a timeline table for
// the first pass through the score, then pause, restart, tempo and reset sequences.
module tb_music_sequencer;

  localparam int TICK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [9:0] low_count;
  logic       note_on;
  logic       note_strobe;
  logic [6:0] crotchet;
  logic       beat_tick;
  logic       loop_pulse;

  int checks  = 0;
  int errors  = 0;
  int edgeNum = 0;

  typedef struct {
    int         edgeAt;
    logic       strobe;
    logic [9:0] low;
    logic       on;
    logic [6:0] step;
    logic       beat;
    logic       loopP;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  music_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .SCORE_LEN (128),
    .PERIOD_W  (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .restart     (restart),
    .tempo_sel   (tempo_sel),
    .low_count   (low_count),
    .note_on     (note_on),
    .note_strobe (note_strobe),
    .crotchet    (crotchet),
    .beat_tick   (beat_tick),
    .loop_pulse  (loop_pulse)
  );

  // Edges are counted from the moment run is first raised; samples land 1 time unit after each edge.
  task automatic goto(input int e);
    while (edgeNum < e) begin
      @(posedge clk);
      #1;
      edgeNum++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rs, input logic [1:0] ts);
    run       = r;
    restart   = rs;
    tempo_sel = ts;
  endtask

  task automatic checkOutput(input string name, input logic s, input logic [9:0] low,
                             input logic on, input logic [6:0] st, input logic b, input logic l);
    checks++;
    if ({note_strobe, low_count, note_on, crotchet, beat_tick, loop_pulse} !== {s, low, on, st, b, l}) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got strobe=%b low=%0d on=%b step=%0d beat=%b loop=%b, want strobe=%b low=%0d on=%b step=%0d beat=%b loop=%b",
               name, edgeNum, note_strobe, low_count, note_on, crotchet, beat_tick, loop_pulse,
               s, low, on, st, b, l);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s @edge %0d: got %b, want %b", name, edgeNum, actual, expected);
    end
  endtask

  task automatic addVec(input int e, input logic s, input logic [9:0] low, input logic on,
                        input logic [6:0] st, input logic b, input logic l);
    vec_t v;
    v.edgeAt = e; v.strobe = s; v.low = low; v.on = on; v.step = st; v.beat = b; v.loopP = l;
    vecs.push_back(v);
  endtask

  initial begin
    // Score: 0 = pitch10/dur3 (595), 1 = rest/dur1, 2 = pitch20/dur0 (334),
    // 3 = pitch21/dur0 (315), 4 = pitch22/dur2 (297), 5 = end marker.
    addVec(1,  1'b1, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    addVec(2,  1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    addVec(9,  1'b0, 10'd595, 1'b1, 7'd0, 1'b1, 1'b0);
    addVec(10, 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    addVec(24, 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    addVec(25, 1'b0, 10'd595, 1'b0, 7'd0, 1'b1, 1'b0);
    addVec(32, 1'b0, 10'd595, 1'b0, 7'd0, 1'b0, 1'b0);
    addVec(33, 1'b0, 10'd595, 1'b0, 7'd1, 1'b1, 1'b0);
    addVec(34, 1'b1, 10'd0,   1'b0, 7'd1, 1'b0, 1'b0);
    addVec(42, 1'b0, 10'd0,   1'b0, 7'd1, 1'b1, 1'b0);
    addVec(50, 1'b0, 10'd0,   1'b0, 7'd2, 1'b1, 1'b0);
    addVec(51, 1'b1, 10'd334, 1'b1, 7'd2, 1'b0, 1'b0);
    addVec(59, 1'b0, 10'd334, 1'b1, 7'd3, 1'b1, 1'b0);
    addVec(60, 1'b1, 10'd315, 1'b1, 7'd3, 1'b0, 1'b0);
    addVec(68, 1'b0, 10'd315, 1'b1, 7'd4, 1'b1, 1'b0);
    addVec(69, 1'b1, 10'd297, 1'b1, 7'd4, 1'b0, 1'b0);
    addVec(85, 1'b0, 10'd297, 1'b0, 7'd4, 1'b1, 1'b0);
    addVec(93, 1'b0, 10'd297, 1'b0, 7'd5, 1'b1, 1'b0);
    addVec(94, 1'b0, 10'd297, 1'b0, 7'd0, 1'b0, 1'b1);
    addVec(95, 1'b1, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    addVec(96, 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 10'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 2'd0);
    edgeNum = 0;

    foreach (vecs[i]) begin
      goto(vecs[i].edgeAt);
      checkOutput($sformatf("timeline_%0d", vecs[i].edgeAt), vecs[i].strobe, vecs[i].low,
                  vecs[i].on, vecs[i].step, vecs[i].beat, vecs[i].loopP);
    end

    // Pause 50 cycles with the tick counter at 5 of 0..7, then resume.
    goto(100);
    applyStimulus(1'b0, 1'b0, 2'd0);
    goto(120);
    checkOutput("pause_hold", 1'b0, 10'd595, 1'b0, 7'd0, 1'b0, 1'b0);
    goto(150);
    applyStimulus(1'b1, 1'b0, 2'd0);
    goto(152);
    checkOutput("resume_pre_beat", 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    goto(153);
    checkOutput("resume_beat", 1'b0, 10'd595, 1'b1, 7'd0, 1'b1, 1'b0);
    goto(168);
    checkOutput("resume_gate_high", 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    goto(169);
    checkOutput("resume_gap", 1'b0, 10'd595, 1'b0, 7'd0, 1'b1, 1'b0);
    goto(176);
    checkOutput("resume_pre_advance", 1'b0, 10'd595, 1'b0, 7'd0, 1'b0, 1'b0);
    goto(177);
    checkOutput("resume_advance", 1'b0, 10'd595, 1'b0, 7'd1, 1'b1, 1'b0);
    goto(178);
    checkOutput("rest_strobe", 1'b1, 10'd0, 1'b0, 7'd1, 1'b0, 1'b0);

    // Restart lands on the same edge as the rest's advancing beat.
    goto(193);
    checkOutput("pre_restart", 1'b0, 10'd0, 1'b0, 7'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0);
    goto(194);
    checkOutput("restart_wins", 1'b0, 10'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    goto(195);
    checkOutput("restart_strobe", 1'b1, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);

    // Faster tempo requested mid-note; the current 8-clock tick finishes first.
    goto(205);
    applyStimulus(1'b1, 1'b0, 2'd2);
    goto(210);
    checkOutput("tempo_old_tick", 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    goto(211);
    checkOutput("tempo_old_wrap", 1'b0, 10'd595, 1'b1, 7'd0, 1'b1, 1'b0);
    goto(212);
    checkOutput("tempo_new_low", 1'b0, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    goto(213);
    checkOutput("tempo_new_beat", 1'b0, 10'd595, 1'b0, 7'd0, 1'b1, 1'b0);
    goto(221);
    checkOutput("legato_first", 1'b1, 10'd334, 1'b1, 7'd2, 1'b0, 1'b0);
    for (int e = 222; e <= 230; e++) begin
      goto(e);
      checkBit($sformatf("legato_on_%0d", e), note_on, 1'b1);
      if (e == 224)
        checkOutput("legato_second", 1'b1, 10'd315, 1'b1, 7'd3, 1'b0, 1'b0);
    end
    goto(231);
    checkOutput("fast_gap", 1'b0, 10'd297, 1'b0, 7'd4, 1'b1, 1'b0);
    goto(234);
    checkOutput("fast_loop", 1'b0, 10'd297, 1'b0, 7'd0, 1'b0, 1'b1);
    goto(235);
    checkOutput("fast_loop_strobe", 1'b1, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);
    goto(244);
    checkOutput("fast_rest_strobe", 1'b1, 10'd0, 1'b0, 7'd1, 1'b0, 1'b0);

    // Restart while paused; playback begins only on resume.
    goto(245);
    applyStimulus(1'b0, 1'b1, 2'd2);
    goto(246);
    checkOutput("paused_restart", 1'b0, 10'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd2);
    goto(250);
    checkOutput("paused_idle", 1'b0, 10'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    goto(252);
    applyStimulus(1'b1, 1'b0, 2'd2);
    goto(253);
    checkOutput("resume_from_restart", 1'b1, 10'd595, 1'b1, 7'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a sounding note.
    goto(255);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 10'd0, 1'b0, 7'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
